// File: rtl/prng_pkg.sv
// Shared PRNG definitions: FSM state encodings and default LFSR constants.
package prng_pkg;

   typedef enum logic [1:0] {
      PRNG_IDLE     = 2'b00,
      PRNG_SHIFT    = 2'b01,
      PRNG_DATAOUT  = 2'b10,
      PRNG_SEEDLOAD = 2'b11
   } prng_state_e;

   localparam int unsigned PRNG_WIDTH_DEFAULT = 32;
   // x^32 + x^22 + x^2 + x + 1, x^32 term implicit
   localparam logic [31:0] PRNG_TAPS_DEFAULT  = 32'h0040_0007;
   localparam logic [31:0] PRNG_SEED_DEFAULT  = 32'hACE1_2468;

endpackage

// File: rtl/lfsr_galois_step.sv
// One left-shift Galois LFSR step: purely combinational, current value in, next value out.
module lfsr_galois_step
   import prng_pkg::*;
#(
   parameter int unsigned      WIDTH = PRNG_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PRNG_TAPS_DEFAULT)
) (
   input  logic [WIDTH-1:0] cur,
   output logic [WIDTH-1:0] nxt
);

   assign nxt = {cur[WIDTH-2:0], 1'b0} ^ (cur[WIDTH-1] ? TAPS : '0);

endmodule

// File: rtl/prng_datapath.sv
// PRNG datapath: decodes the FSM state to step the LFSR, shift in a serial seed or stream the word out.
// Optional lock-up recovery enabled by defining PRNG_LOCKUP_GUARD_EN.
module prng_datapath
   import prng_pkg::*;
#(
   parameter int unsigned      WIDTH        = PRNG_WIDTH_DEFAULT,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(PRNG_TAPS_DEFAULT),
   parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(PRNG_SEED_DEFAULT)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [1:0]       state,
   input  logic             seed_in,
   output logic             data_out,
   output logic             data_valid,
   output logic             data_done,
   output logic [WIDTH-1:0] lfsr_q
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   prng_state_e      st;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] lfsr_nxt;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] seed_shift;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] bit_idx;
   logic             cnt_last;

   assign st         = prng_state_e'(state);
   assign cnt_last   = (cnt == CNT_LAST);
   assign seed_shift = {lfsr[WIDTH-2:0], seed_in};

   lfsr_galois_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_step (
      .cur (lfsr),
      .nxt (step_val)
   );

   // Next-state decode for the random word and the bit counter
   always_comb begin
      lfsr_nxt = lfsr;
      cnt_nxt  = '0;
      case (st)
         PRNG_SHIFT: begin
`ifdef PRNG_LOCKUP_GUARD_EN
            lfsr_nxt = (lfsr == '0) ? SEED_DEFAULT : step_val;
`else
            lfsr_nxt = step_val;
`endif
         end
         PRNG_DATAOUT: begin
            cnt_nxt = cnt_last ? '0 : cnt + CNT_W'(1);
         end
         PRNG_SEEDLOAD: begin
`ifdef PRNG_LOCKUP_GUARD_EN
            lfsr_nxt = (cnt_last && seed_shift == '0) ? SEED_DEFAULT : seed_shift;
`else
            lfsr_nxt = seed_shift;
`endif
            cnt_nxt  = cnt_last ? '0 : cnt + CNT_W'(1);
         end
         default: begin
            lfsr_nxt = lfsr;
            cnt_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lfsr <= SEED_DEFAULT;
         cnt  <= '0;
      end else begin
         lfsr <= lfsr_nxt;
         cnt  <= cnt_nxt;
      end
   end

   // Serialiser: MSB first, counter selects the bit
   assign bit_idx    = CNT_LAST - cnt;
   assign data_valid = (st == PRNG_DATAOUT);
   assign data_out   = data_valid ? lfsr[bit_idx] : 1'b0;
   assign data_done  = ((st == PRNG_DATAOUT) || (st == PRNG_SEEDLOAD)) && cnt_last;
   assign lfsr_q     = lfsr;

endmodule

// File: tb/tb_prng_datapath.sv
// Self-checking bench for prng_datapath: directed cases plus randomized traffic against a polynomial model.
module tb_prng_datapath;

   localparam int          W      = 32;
   localparam logic [1:0]  S_IDLE = 2'b00;
   localparam logic [1:0]  S_SHFT = 2'b01;
   localparam logic [1:0]  S_DOUT = 2'b10;
   localparam logic [1:0]  S_SEED = 2'b11;
   localparam logic [32:0] POLY   = 33'h1_0040_0007;
   localparam logic [31:0] SEED   = 32'hACE1_2468;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [1:0]  st = S_IDLE;
   logic        seed_in = 1'b0;
   logic        data_out;
   logic        data_valid;
   logic        data_done;
   logic [31:0] lfsr_q;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_lfsr = SEED;
   int          m_cnt = 0;
   int          done_seen = 0;

   always #5 clk = ~clk;

   prng_datapath dut (
      .clk        (clk),
      .rstn       (rstn),
      .state      (st),
      .seed_in    (seed_in),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_done  (data_done),
      .lfsr_q     (lfsr_q)
   );

   // Multiply by x modulo the feedback polynomial
   function automatic logic [31:0] mul_x(input logic [31:0] v);
      logic [32:0] t;
      t = {v, 1'b0};
      if (t[32]) t = t ^ POLY;
      return t[31:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock with given state/seed bit: check decoded outputs, then the registered word
   task automatic cycle(input logic [1:0] s, input logic b, output logic bit_o);
      logic e_valid, e_out, e_done;
      @(negedge clk);
      st = s;
      seed_in = b;
      #1;
      e_valid = (s == S_DOUT);
      e_out   = e_valid ? m_lfsr[W-1-m_cnt] : 1'b0;
      e_done  = ((s == S_DOUT) || (s == S_SEED)) && (m_cnt == W-1);
      chk("data_valid", 32'(data_valid), 32'(e_valid));
      chk("data_out",   32'(data_out),   32'(e_out));
      chk("data_done",  32'(data_done),  32'(e_done));
      bit_o = data_out;
      if (data_done) done_seen++;
      case (s)
         S_SHFT: begin
            m_cnt = 0;
`ifdef PRNG_LOCKUP_GUARD_EN
            if (m_lfsr == 32'h0) m_lfsr = SEED;
            else m_lfsr = mul_x(m_lfsr);
`else
            m_lfsr = mul_x(m_lfsr);
`endif
         end
         S_DOUT: m_cnt = (m_cnt + 1) % W;
         S_SEED: begin
            m_lfsr = {m_lfsr[30:0], b};
`ifdef PRNG_LOCKUP_GUARD_EN
            if (m_cnt == W-1 && m_lfsr == 32'h0) m_lfsr = SEED;
`endif
            m_cnt = (m_cnt + 1) % W;
         end
         default: m_cnt = 0;
      endcase
      @(posedge clk);
      #1;
      chk("lfsr_q", lfsr_q, m_lfsr);
   endtask

   task automatic run(input logic [1:0] s, input int n);
      logic d;
      for (int i = 0; i < n; i++) cycle(s, 1'b0, d);
   endtask

   // Stream a whole word and compare it with the word held before the transaction
   task automatic dataout_word(input string tag);
      logic [31:0] word, exp;
      logic        d;
      exp = m_lfsr;
      done_seen = 0;
      for (int i = 0; i < W; i++) begin
         cycle(S_DOUT, 1'b0, d);
         word = {word[30:0], d};
      end
      chk(tag, word, exp);
      chk("dout_done_count", 32'(done_seen), 32'd1);
   endtask

   task automatic seedload(input logic [31:0] w);
      logic d;
      done_seen = 0;
      for (int i = W-1; i >= 0; i--) cycle(S_SEED, w[i], d);
      chk("seed_done_count", 32'(done_seen), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      st = S_IDLE;
      #1;
      chk("rst_lfsr_q", lfsr_q, SEED);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_data_valid", 32'(data_valid), 32'd0);
      chk("rst_data_done", 32'(data_done), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      m_lfsr = SEED;
      m_cnt = 0;
   endtask

   initial begin
      logic d;
      logic [31:0] first_bits;

      // Reset and idle
      do_reset();
      run(S_IDLE, 2);
      chk("idle_hold", lfsr_q, 32'hACE1_2468);

      // First step from the reset value
      run(S_SHFT, 1);
      chk("shift_once", lfsr_q, 32'h5982_48D7);

      // Stream the reset word, checking the leading bits against the known pattern
      do_reset();
      first_bits = '0;
      done_seen = 0;
      for (int i = 0; i < W; i++) begin
         cycle(S_DOUT, 1'b0, d);
         first_bits = {first_bits[30:0], d};
      end
      chk("dout_reset_word", first_bits, 32'hACE1_2468);
      chk("dout_first_byte", 32'(first_bits[31:24]), 32'hAC);
      chk("dout_reset_done", 32'(done_seen), 32'd1);
      run(S_SHFT, 1);

      // Seed of one, then one step
      seedload(32'h0000_0001);
      chk("seed_one", lfsr_q, 32'h0000_0001);
      run(S_SHFT, 1);
      chk("seed_one_step", lfsr_q, 32'h0000_0002);

      // All-zero seed
      seedload(32'h0);
`ifdef PRNG_LOCKUP_GUARD_EN
      chk("seed_zero_guard", lfsr_q, 32'hACE1_2468);
`else
      chk("seed_zero", lfsr_q, 32'h0);
      run(S_SHFT, 3);
      chk("seed_zero_locked", lfsr_q, 32'h0);
`endif
      run(S_SHFT, 1);

      // Reset in the middle of a seed load
      do_reset();
      run(S_SHFT, 1);
      for (int i = 0; i < 10; i++) cycle(S_SEED, 1'($urandom_range(0, 1)), d);
      @(negedge clk);
      st = S_SEED;
      seed_in = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      chk("midrst_lfsr_q", lfsr_q, 32'hACE1_2468);
      chk("midrst_done", 32'(data_done), 32'd0);
      @(negedge clk);
      st = S_IDLE;
      rstn = 1'b1;
      m_lfsr = SEED;
      m_cnt = 0;
      dataout_word("midrst_dout_word");
      run(S_SHFT, 1);

      // Randomized transactions
      for (int r = 0; r < 6; r++) begin
         run(S_SHFT, $urandom_range(1, 20));
         dataout_word("rand_dout_word");
         run(S_SHFT, 1);
         run(S_IDLE, $urandom_range(0, 3));
         seedload($urandom);
         run(S_SHFT, $urandom_range(1, 5));
         dataout_word("rand_seed_dout_word");
         run(S_SHFT, 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
